// File: rtl/ring_alarm_sequencer.sv
// rtl/ring_alarm_sequencer.sv - blink sequencer for the ring alarm picture
//
// Purpose: on a rising edge of timer_done (while enabled) runs an alarm that
// blinks the ring picture in SHOW/HIDE half-periods counted in video frames,
// keeps the ball picture up for the whole alarm, and ends on expiry, ack or
// loss of enable.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   frame_tick   one-cycle pulse per video frame
//   enable       alarm enable level; low aborts/blocks ringing
//   timer_done   timer expiry level; rising edge starts an alarm
//   ack          user acknowledge level (synchronized, debounced)
//   ring_show    high while the ring picture is drawn
//   ball_show    high for the whole alarm
//   ringing      alarm in progress
//   done_pulse   one-cycle pulse when an alarm ends by expiry or ack
//   alarm_count  alarms started, saturating at 255

module ring_alarm_sequencer #(
  parameter int HALF_FRAMES = 15,
  parameter int MAX_HALVES  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       timer_done,
  input  logic       ack,
  output logic       ring_show,
  output logic       ball_show,
  output logic       ringing,
  output logic       done_pulse,
  output logic [7:0] alarm_count
);

  // A single-frame half-period would give a zero-width counter; keep one bit.
  localparam int FW = (HALF_FRAMES > 1) ? $clog2(HALF_FRAMES) : 1;
  localparam int HW = $clog2(MAX_HALVES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(HALF_FRAMES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(MAX_HALVES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, HIDE} state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] half_cnt;
  logic          td_prev;
  logic          td_rise;

  // td_prev resets high so a level held through reset is not seen as an edge.
  assign td_rise = timer_done & ~td_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      half_cnt    <= '0;
      td_prev     <= 1'b1;
      ring_show   <= 1'b0;
      ball_show   <= 1'b0;
      ringing     <= 1'b0;
      done_pulse  <= 1'b0;
      alarm_count <= 8'd0;
    end else begin
      td_prev    <= timer_done;
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // ack is ignored here; edges during an alarm were already consumed
          // by td_prev, so only a fresh edge can start the next alarm.
          if (enable && td_rise) begin
            state     <= SHOW;
            frame_cnt <= '0;
            half_cnt  <= '0;
            ring_show <= 1'b1;
            ball_show <= 1'b1;
            ringing   <= 1'b1;
            if (alarm_count != 8'hFF) alarm_count <= alarm_count + 8'd1;
          end
        end
        SHOW, HIDE: begin
          // Priority: enable loss (silent abort) > ack > frame_tick.
          if (!enable) begin
            state     <= IDLE;
            ring_show <= 1'b0;
            ball_show <= 1'b0;
            ringing   <= 1'b0;
          end else if (ack) begin
            state      <= IDLE;
            ring_show  <= 1'b0;
            ball_show  <= 1'b0;
            ringing    <= 1'b0;
            done_pulse <= 1'b1;
          end else if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (half_cnt == HALF_LAST) begin
                state      <= IDLE;
                ring_show  <= 1'b0;
                ball_show  <= 1'b0;
                ringing    <= 1'b0;
                done_pulse <= 1'b1;
              end else begin
                half_cnt <= half_cnt + 1'b1;
                if (state == SHOW) begin
                  state     <= HIDE;
                  ring_show <= 1'b0;
                end else begin
                  state     <= SHOW;
                  ring_show <= 1'b1;
                end
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ring_show <= 1'b0;
          ball_show <= 1'b0;
          ringing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ring_alarm_sequencer.md
RING_ALARM_SEQUENCER -- requirements
Module: ring_alarm_sequencer

Interface
REQ-001 Parameter HALF_FRAMES, default 15, frame ticks per blink half-period (≥1).
REQ-002 Parameter MAX_HALVES, default 40, half-periods per alarm before self-termination (≥2, even).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse, one per video frame (end of visible region).
REQ-006 enable  input  1  alarm enable level; low disables ringing.
REQ-007 timer_done  input  1  timer expiry level; its rising edge starts an alarm.
REQ-008 ack  input  1  user acknowledge level, already synchronized and debounced.
REQ-009 ring_show  output  1  gate for the ring picture region; high while the ring is drawn.
REQ-010 ball_show  output  1  gate for the ring-ball picture region; high for the whole alarm.
REQ-011 ringing  output  1  status, alarm in progress.
REQ-012 done_pulse  output  1  one-cycle pulse when an alarm ends by expiry or ack.
REQ-013 alarm_count  output  8  number of alarms started, saturating at 255.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states SHALL be IDLE, SHOW, HIDE.
REQ-016 Start: in IDLE with enable=1, timer_done sampled 1 while its previous sample was 0 -> SHOW; frame_cnt=0, half_cnt=0; alarm_count+1 (saturate at 255).
REQ-017 The previous-sample register of timer_done SHALL reset to 1, so a level held high through reset does not start an alarm.
REQ-018 SHOW: ring_show=1, ball_show=1, ringing=1. HIDE: ring_show=0, ball_show=1, ringing=1. IDLE: all three 0.
REQ-019 In SHOW/HIDE, each frame_tick increments frame_cnt; on a tick with frame_cnt=HALF_FRAMES-1: frame_cnt=0, half_cnt+1, state toggles SHOW<->HIDE.
REQ-020 On that toggle tick with half_cnt=MAX_HALVES-1: go to IDLE and assert done_pulse for one cycle (expiry).
REQ-021 Total alarm length SHALL be exactly HALF_FRAMES*MAX_HALVES frame ticks.
REQ-022 Counter widths SHALL be clog2 of their parameter range; no wrap before the terminal compare.
REQ-023 ack=1 in SHOW/HIDE: go to IDLE and assert done_pulse next cycle; ack has priority over a same-cycle frame_tick.
REQ-024 ack in IDLE SHALL be ignored.
REQ-025 enable=0 in SHOW/HIDE: abort to IDLE with no done_pulse; enable=0 has priority over ack and frame_tick.
REQ-026 New timer_done rising edge during SHOW/HIDE SHALL be ignored: no restart, no alarm_count change.
REQ-027 A timer_done rising edge in the same cycle the FSM returns to IDLE SHALL be ignored. A new alarm requires a later edge.
REQ-028 done_pulse SHALL never be high in two consecutive cycles.

Reset
REQ-029 Reset asserted SHALL immediately force IDLE, ring_show=0, ball_show=0, ringing=0, done_pulse=0, alarm_count=0, frame_cnt=0, half_cnt=0, timer_done previous-sample=1.
REQ-030 Reset mid-alarm SHALL terminate without done_pulse. After release, the block waits in IDLE for a fresh timer_done edge.

Verification (HALF_FRAMES=2, MAX_HALVES=4)
REQ-031 enable=1, timer_done 0->1, then 8 frame_ticks -> states SHOW, SHOW, HIDE, HIDE, SHOW, SHOW, HIDE, HIDE, each for 2 ticks. IDLE after the 8th tick, one done_pulse, alarm_count=1.
REQ-032 Start alarm, ack=1 coincident with the 3rd frame_tick -> IDLE next cycle, done_pulse=1 for one cycle, no state toggle on that tick.
REQ-033 Start alarm, drop enable after 1 tick -> IDLE next cycle, done_pulse stays 0, ring_show=ball_show=0.
REQ-034 timer_done held 1 across reset release, enable=1 -> stays IDLE, alarm_count=0; a later 0->1 edge starts SHOW.
REQ-035 Second timer_done edge during HIDE -> no restart, expiry still after 8 total ticks, alarm_count=1.
REQ-036 Run 256 complete alarms -> alarm_count saturates at 255. Reset mid-SHOW -> all outputs 0 asynchronously, no done_pulse.
